fpu_exec_dispatcher: RTL

Issue-side controller that drives the FPU ALU exec element through its start/complete protocol. Accepts one decoded FP instruction with operands, pulses the element's start (its "reset" input) for START_CYCLES cycles, waits for `completed`, then presents the result on a backpressured writeback port. Sits between the FP issue stage and the FPU ALU exec element; it guards against hung elements with a timeout and against illegal opcodes with a reject path.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_exec_dispatcher.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue path: opcode values, dispatcher state
// encoding and the captured-instruction record.
package fpu_pkg;

  localparam logic [5:0] ABS_S   = 6'd54;
  localparam logic [5:0] NEG_S   = 6'd55;
  localparam logic [5:0] ADD_S   = 6'd56;
  localparam logic [5:0] SUB_S   = 6'd57;
  localparam logic [5:0] MUL_S   = 6'd58;
  localparam logic [5:0] DIV_S   = 6'd59;
  localparam logic [5:0] CVT_S_W = 6'd60;
  localparam logic [5:0] CVT_W_S = 6'd61;
  localparam logic [5:0] MOV_S   = 6'd62;
  localparam logic [5:0] SQRT_S  = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } disp_state_e;

  typedef struct packed {
    logic [5:0]  inst_num;
    logic [31:0] fs;
    logic [31:0] ft;
    logic [4:0]  fd;
  } fpu_issue_t;

endpackage

// File: rtl/fpu_exec_dispatcher.sv
// Drives one FPU exec element through start/complete for a single instruction,
// with an illegal-opcode reject path and a hung-element timeout.
module fpu_exec_dispatcher
  import fpu_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int INST_LO      = 54,
  parameter int INST_HI      = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_inst_num,
  input  logic [31:0] issue_fs,
  input  logic [31:0] issue_ft,
  input  logic [4:0]  issue_fd,
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_fs,
  output logic [31:0] elem_ft,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_fd,
  output logic [31:0] wb_data,
  output logic        wb_illegal,
  output logic        wb_timeout
);

  localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  disp_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fpu_issue_t    op_q, op_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          issue_ready_q, issue_ready_d;
  logic          elem_reset_q, elem_reset_d;
  logic          wb_valid_q, wb_valid_d;
  logic          issue_legal_s;

  assign issue_legal_s = (int'({26'd0, issue_inst_num}) >= INST_LO) &&
                         (int'({26'd0, issue_inst_num}) <= INST_HI);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          state_d = issue_legal_s ? ST_START : ST_WB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WAIT: begin
        // Completion is checked first so it wins over a same-edge timeout.
        if (elem_completed || (cnt_q == WAIT_LAST)) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    wb_data_d = wb_data_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (issue_valid) begin
          op_d.inst_num = issue_inst_num;
          op_d.fs       = issue_fs;
          op_d.ft       = issue_ft;
          op_d.fd       = issue_fd;
          if (issue_legal_s) begin
            illegal_d = 1'b0;
          end else begin
            wb_data_d = 32'd0;
            illegal_d = 1'b1;
          end
        end else begin
          op_d = op_q;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (elem_completed) begin
          wb_data_d = elem_out;
          timeout_d = 1'b0;
        end else if (cnt_q == WAIT_LAST) begin
          wb_data_d = 32'd0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end else begin
          illegal_d = illegal_q;
        end
      end
      default: cnt_d = '0;
    endcase
    issue_ready_d = (state_d == ST_IDLE);
    elem_reset_d  = (state_d == ST_START);
    wb_valid_d    = (state_d == ST_WB);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      op_q          <= '0;
      wb_data_q     <= 32'd0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      issue_ready_q <= 1'b1;
      elem_reset_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      wb_data_q     <= wb_data_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      issue_ready_q <= issue_ready_d;
      elem_reset_q  <= elem_reset_d;
      wb_valid_q    <= wb_valid_d;
    end
  end

  assign issue_ready   = issue_ready_q;
  assign elem_reset    = elem_reset_q;
  assign elem_inst_num = op_q.inst_num;
  assign elem_fs       = op_q.fs;
  assign elem_ft       = op_q.ft;
  assign wb_valid      = wb_valid_q;
  assign wb_fd         = op_q.fd;
  assign wb_data       = wb_data_q;
  assign wb_illegal    = illegal_q;
  assign wb_timeout    = timeout_q;

endmodule
